// File: rtl/vec_alu_seq_pkg.sv
// Shared definitions for the vector ALU sequencer.
//   XLEN / VLEN : element width and maximum element count
//   OP_*        : opcodes understood by the external 32-bit ALU
//   state_e     : sequencer FSM states
//   req_legal   : true when an accepted request can be executed
package vec_alu_seq_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned VLEN = 8;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_LSL = 4'd3;
  localparam logic [3:0] OP_LSR = 4'd4;
  localparam logic [3:0] OP_ROR = 4'd5;
  localparam logic [3:0] OP_ROL = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Opcodes above OP_ROL are illegal; length must be 1..VLEN.
  function automatic logic req_legal(input logic [3:0] op, input logic [3:0] len);
    return (op <= OP_ROL) && (len != 4'd0) && (len <= 4'(VLEN));
  endfunction

endpackage

// File: rtl/vec_alu_seq.sv
// Vector ALU sequencer: accepts a request of up to 8 packed 32-bit element
// pairs, feeds them one per cycle through an external combinational ALU,
// collects results and per-element zero flags, then presents a response.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_op, req_len             opcode (0..6 legal) and element count (1..8)
//   req_a, req_b                packed operand vectors
//   alu_ctl, alu_a, alu_b       drive to external ALU (zero outside RUN)
//   alu_out, alu_zero           same-cycle ALU result and zero flag
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_zmask, rsp_err packed results, zero flags, illegal-request flag
module vec_alu_seq
  import vec_alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [3:0]           req_len,
  input  logic [XLEN*VLEN-1:0] req_a,
  input  logic [XLEN*VLEN-1:0] req_b,
  output logic [3:0]           alu_ctl,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  input  logic [XLEN-1:0]      alu_out,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN*VLEN-1:0] rsp_data,
  output logic [VLEN-1:0]      rsp_zmask,
  output logic                 rsp_err
);

  state_e                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [3:0]            op_q, op_d;
  logic [3:0]            len_q, len_d;
  logic [XLEN*VLEN-1:0]  a_q, a_d;
  logic [XLEN*VLEN-1:0]  b_q, b_d;
  logic [XLEN*VLEN-1:0]  res_q, res_d;
  logic [VLEN-1:0]       zm_q, zm_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    len_d     = len_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    zm_d      = zm_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_ctl   = '0;
    alu_a     = '0;
    alu_b     = '0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d  = req_op;
          len_d = req_len;
          a_d   = req_a;
          b_d   = req_b;
          res_d = '0;
          zm_d  = '0;
          idx_d = '0;
          if (req_legal(req_op, req_len)) begin
            err_d   = 1'b0;
            state_d = ST_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        alu_ctl = op_q;
        alu_a   = a_q[XLEN*int'(idx_q) +: XLEN];
        alu_b   = b_q[XLEN*int'(idx_q) +: XLEN];
        res_d[XLEN*int'(idx_q) +: XLEN] = alu_out;
        zm_d[idx_q] = alu_zero;
        idx_d = idx_q + 3'd1;
        // len_q is 1..8 here, so len_q-1 fits the 3-bit index range.
        if ({1'b0, idx_q} == (len_q - 4'd1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      len_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zm_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      len_q   <= len_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zm_q    <= zm_d;
      err_q   <= err_d;
    end
  end

  assign rsp_data  = res_q;
  assign rsp_zmask = zm_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_vec_alu_seq.sv
module tb_vec_alu_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [3:0]   req_len;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic [3:0]   alu_ctl;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic [31:0]  alu_out;
  logic         alu_zero;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_data;
  logic [7:0]   rsp_zmask;
  logic         rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External combinational ALU.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  s;
    logic [63:0] aa;
    s  = b[4:0];
    aa = {a, a};
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      4'd3:    return a << s;
      4'd4:    return a >> s;
      4'd5:    return 32'(aa >> s);
      4'd6:    return 32'((aa << s) >> 32);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out  = alu_fn(alu_ctl, alu_a, alu_b);
  assign alu_zero = (alu_out == 32'd0);

  vec_alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_len   (req_len),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_ctl   (alu_ctl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zmask (rsp_zmask),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a transaction is either waiting, running for a
  // number of remaining cycles, or holding a precomputed response.
  bit           m_ready = 1'b1;
  bit           m_valid = 1'b0;
  int           m_run   = 0;
  int           m_len   = 0;
  logic [3:0]   m_op    = '0;
  logic [255:0] m_a     = '0;
  logic [255:0] m_b     = '0;
  logic [255:0] m_data  = '0;
  logic [7:0]   m_zm    = '0;
  logic         m_err   = 1'b0;
  bit           chk_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b1;
      m_valid = 1'b0;
      m_run   = 0;
    end else if (m_ready) begin
      if (req_valid) begin
        m_ready = 1'b0;
        m_op    = req_op;
        m_len   = int'(req_len);
        m_a     = req_a;
        m_b     = req_b;
        m_data  = '0;
        m_zm    = '0;
        if (req_op <= 4'd6 && req_len >= 4'd1 && req_len <= 4'd8) begin
          for (int i = 0; i < m_len; i++) begin
            m_data[32*i +: 32] = alu_fn(m_op, m_a[32*i +: 32], m_b[32*i +: 32]);
            m_zm[i] = (m_data[32*i +: 32] == 32'd0);
          end
          m_err = 1'b0;
          m_run = m_len;
        end else begin
          m_err   = 1'b1;
          m_valid = 1'b1;
        end
      end
    end else if (m_run > 0) begin
      m_run--;
      if (m_run == 0) m_valid = 1'b1;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 256'(req_ready), 256'(m_ready));
      chk("rsp_valid", 256'(rsp_valid), 256'(m_valid));
      if (m_valid) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_zmask", 256'(rsp_zmask), 256'(m_zm));
        chk("rsp_err", 256'(rsp_err), 256'(m_err));
      end
      if (m_run > 0) begin
        chk("alu_ctl", 256'(alu_ctl), 256'(m_op));
        chk("alu_a", 256'(alu_a), 256'(m_a[32*(m_len-m_run) +: 32]));
        chk("alu_b", 256'(alu_b), 256'(m_b[32*(m_len-m_run) +: 32]));
      end else begin
        chk("alu_idle", 256'({alu_ctl, alu_a, alu_b}), 256'(0));
      end
    end
  end

  // Issue one request from IDLE and wait for rsp_valid; returns at the
  // negedge (+1) where rsp_valid is first seen. exp_n = cycles without valid.
  task automatic do_req(input logic [3:0] op, input logic [3:0] len,
                        input logic [255:0] a, input logic [255:0] b, input int exp_n);
    int n;
    bit got;
    req_valid = 1'b1;
    req_op    = op;
    req_len   = len;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      n++;
    end
    #1;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting rsp_valid: got 0 expected 1");
    end else begin
      chk("latency", 256'(n), 256'(exp_n));
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  logic [255:0] va, vb, vd;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_len = '0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("reset_ready", 256'(req_ready), 256'(1));
    chk("reset_valid", 256'(rsp_valid), 256'(0));
    chk("reset_data", rsp_data, 256'(0));
    chk("reset_zm_err", 256'({rsp_zmask, rsp_err}), 256'(0));
    @(posedge clk); #1;

    // add, len 3
    va = '0; vb = '0;
    va[31:0] = 32'd1; va[63:32] = 32'd2; va[95:64] = 32'hFFFF_FFFF;
    vb[31:0] = 32'd1; vb[63:32] = 32'd3; vb[95:64] = 32'd1;
    do_req(4'd0, 4'd3, va, vb, 3);
    vd = '0; vd[31:0] = 32'd2; vd[63:32] = 32'd5;
    chk("add_data", rsp_data, vd);
    chk("add_zmask", 256'(rsp_zmask), 256'(8'b0000_0100));
    chk("add_err", 256'(rsp_err), 256'(0));
    release_rsp();

    // sub, len 8, all 7
    va = {8{32'd7}};
    do_req(4'd1, 4'd8, va, va, 8);
    chk("sub_data", rsp_data, 256'(0));
    chk("sub_zmask", 256'(rsp_zmask), 256'(8'hFF));
    release_rsp();

    // illegal op, then len 0
    do_req(4'd9, 4'd4, {8{32'h1234_5678}}, {8{32'd1}}, 0);
    chk("badop_err", 256'(rsp_err), 256'(1));
    chk("badop_data", rsp_data, 256'(0));
    chk("badop_zmask", 256'(rsp_zmask), 256'(0));
    release_rsp();
    do_req(4'd0, 4'd0, {8{32'd3}}, {8{32'd3}}, 0);
    chk("len0_err", 256'(rsp_err), 256'(1));
    chk("len0_data", rsp_data, 256'(0));
    release_rsp();
    do_req(4'd2, 4'd9, {8{32'd3}}, {8{32'd5}}, 0);
    chk("len9_err", 256'(rsp_err), 256'(1));
    release_rsp();

    // lsl with backpressure
    va = '0; vb = '0;
    va[31:0] = 32'd1; va[63:32] = 32'd1;
    vb[31:0] = 32'd4; vb[63:32] = 32'd31;
    do_req(4'd3, 4'd2, va, vb, 2);
    vd = '0; vd[31:0] = 32'h10; vd[63:32] = 32'h8000_0000;
    for (int k = 0; k < 5; k++) begin
      chk("lsl_hold_data", rsp_data, vd);
      chk("lsl_hold_ready", 256'({req_ready, rsp_valid}), 256'(2'b01));
      @(negedge clk); #1;
    end
    release_rsp();

    // reset during RUN cycle 2 of len 6
    req_valid = 1'b1; req_op = 4'd0; req_len = 4'd6;
    req_a = {8{32'd9}}; req_b = {8{32'd1}};
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_ready", 256'(req_ready), 256'(1));
    chk("abort_valid", 256'(rsp_valid), 256'(0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      chk("abort_no_rsp", 256'(rsp_valid), 256'(0));
    end
    @(posedge clk); #1;
    va = '0; vb = '0;
    va[31:0] = 32'h8000_0001; vb[31:0] = 32'd1;
    va[63:32] = 32'h0000_00F0; vb[63:32] = 32'd4;
    do_req(4'd5, 4'd2, va, vb, 2);
    vd = '0; vd[31:0] = 32'hC000_0000; vd[63:32] = 32'h0000_000F;
    chk("ror_data", rsp_data, vd);
    chk("ror_zmask", 256'(rsp_zmask), 256'(0));
    release_rsp();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 79) == 0);
      req_valid = $urandom_range(0, 1);
      req_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      req_len   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      for (int i = 0; i < 8; i++) begin
        req_a[32*i +: 32] = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        req_b[32*i +: 32] = ($urandom_range(0, 5) == 0) ? req_a[32*i +: 32] : $urandom;
      end
      rsp_ready = $urandom_range(0, 1);
    end
    @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
